munoc_axi_quiesce_ctrl: RTL and testbench
=========================================

MUNOC_AXI_QUIESCE_CTRL -- requirements
Module: munoc_axi_quiesce_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, meaning the maximum in-flight bursts tracked per direction.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum DRAIN duration before forced isolation.
REQ-003 SHALL derive BW_CNT = clog2(MAX_OUTSTANDING+1) and BW_TMR = clog2(TIMEOUT_CYCLES+1).
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  clock; rstnn  in  1  reset, active-low, asynchronous.
REQ-005 SHALL have these ports:
- isolate_req  in  1  level request to isolate the AXI port.
- awvalid, awready, wvalid, wready, wlast, bvalid, bready, arvalid, arready, rvalid, rready, rlast  in  1 each  monitored upstream handshakes.
- block_new  out  1  masks AWVALID/ARVALID upstream.
- block  out  1  drives the AXI isolation gate's block input.
- isolate_ack  out  1  port is isolated.
- drain_timeout  out  1  sticky flag: isolation was forced by timeout.
- cnt_error  out  1  sticky flag: counter overflow or underflow.

Function
REQ-006 SHALL implement three states: OPEN, DRAIN, ISOLATED.
REQ-007 SHALL track these counters:
- wr_cnt: +1 on aw_fire, -1 on b_fire.
- rd_cnt: +1 on ar_fire, -1 on r_fire&rlast.
- wd_bal: signed, width BW_CNT+1; +1 on aw_fire, -1 on w_fire&wlast.
- x_fire = xvalid & xready.
REQ-008 SHALL leave a counter unchanged when its increment and decrement events occur in the same cycle.
REQ-009 SHALL saturate wr_cnt and rd_cnt at MAX_OUTSTANDING and 0, and set cnt_error when an increment at max or a decrement at 0 is seen.
REQ-010 SHALL define drained as wr_cnt==0 & rd_cnt==0 & wd_bal==0.
REQ-011 OPEN->DRAIN SHALL occur when isolate_req=1, but only in a cycle with no stalled address valid, i.e. NOT((awvalid&~awready)|(arvalid&~arready)); otherwise the transition SHALL wait.
REQ-012 On OPEN->DRAIN the block SHALL clear drain_timeout and the timer.
REQ-013 In DRAIN, block_new SHALL be 1, and the timer SHALL increment each cycle.
REQ-014 DRAIN->ISOLATED SHALL occur on drained, or on timer==TIMEOUT_CYCLES-1; the timeout case SHALL set drain_timeout.
REQ-015 DRAIN->OPEN SHALL occur if isolate_req drops before drained; withdrawal SHALL take priority over drained in the same cycle.
REQ-016 In ISOLATED: block=1, block_new=1, isolate_ack=1; ISOLATED->OPEN SHALL occur when isolate_req=0.
REQ-017 Outputs SHALL be registered and reflect the new state one cycle after the transition condition.
REQ-018 Counters SHALL keep counting in all states; once ISOLATED the outputs SHALL not depend on counter values.

Reset
REQ-019 Reset SHALL force state=OPEN, counters=0, timer=0, and block=block_new=isolate_ack=drain_timeout=cnt_error=0.
REQ-020 Assertion of rstnn mid-DRAIN or mid-ISOLATED SHALL immediately produce the REQ-019 values asynchronously.

Structure
REQ-021 State encoding constants and the derived-width macros SHALL reside in the shared munoc include/package.
REQ-022 One sub-module, munoc_quiesce_counter (up/down saturating counter with error flag), SHALL be instantiated twice, for wr_cnt and rd_cnt.

Verification
REQ-023 Idle port, isolate_req=1 at cycle 0 -> block_new=1 at cycle 1, block=1 and isolate_ack=1 at cycle 2.
REQ-024 Two AW and one AR accepted, then isolate_req=1 -> block stays 0 until 2 B fires, 2 wlast fires and 1 rlast fire; block=1 the cycle after the last.
REQ-025 awvalid=1 with awready=0 when isolate_req rises -> block_new stays 0 until the aw_fire cycle, then DRAIN.
REQ-026 TIMEOUT_CYCLES=16, one B never returned -> block=1 and drain_timeout=1 exactly 16 cycles after DRAIN entry.
REQ-027 aw_fire and b_fire in the same cycle with wr_cnt=1 -> wr_cnt stays 1.
REQ-028 isolate_req dropped in DRAIN -> OPEN next cycle with block_new=0; rstnn pulsed low in ISOLATED -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/munoc_axi_quiesce_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : munoc_axi_quiesce_ctrl_pkg                                   |
// | Description : Shared state encoding and width helper for the AXI quiesce   |
// |               controller and its counter.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package munoc_axi_quiesce_ctrl_pkg;

  // Port-isolation lifecycle states
  typedef enum logic [1:0] {
    ST_OPEN     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_ISOLATED = 2'd2
  } qstate_e;

  // Bits needed to hold the values 0..n inclusive
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/munoc_axi_quiesce_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : munoc_axi_quiesce_ctrl_if                                    |
// | Description : AXI channel handshake bundle observed by the quiesce        |
// |               controller. master drives, slave only watches.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface munoc_axi_quiesce_ctrl_if;

  logic awvalid;
  logic awready;
  logic wvalid;
  logic wready;
  logic wlast;
  logic bvalid;
  logic bready;
  logic arvalid;
  logic arready;
  logic rvalid;
  logic rready;
  logic rlast;

  modport master (
    output awvalid, awready, wvalid, wready, wlast, bvalid, bready,
           arvalid, arready, rvalid, rready, rlast
  );

  modport slave (
    input  awvalid, awready, wvalid, wready, wlast, bvalid, bready,
           arvalid, arready, rvalid, rready, rlast
  );

endinterface
`default_nettype wire

// File: rtl/munoc_quiesce_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : munoc_quiesce_counter                                        |
// | Description : Saturating up/down outstanding-burst counter with a sticky  |
// |               error flag on increment-at-max or decrement-at-zero.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module munoc_quiesce_counter #(
  parameter int MAX_VAL = 8,
  parameter int BW      = 4
) (
  input  wire logic          clk,
  input  wire logic          rstnn,
  input  wire logic          inc,
  input  wire logic          dec,
  output logic [BW-1:0]      count_nxt,
  output logic               err
);

  localparam logic [BW-1:0] C_MAX = BW'(MAX_VAL);
  localparam logic [BW-1:0] C_ONE = BW'(1);

  logic [BW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // Next count: simultaneous inc/dec cancel; out-of-range steps hold and flag
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec) begin
      if (count_q == C_MAX) err_d = 1'b1;
      else                  count_d = count_q + C_ONE;
    end else if (dec && !inc) begin
      if (count_q == '0)    err_d = 1'b1;
      else                  count_d = count_q - C_ONE;
    end
  end

  // Count and sticky error registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_nxt = count_d;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: rtl/munoc_axi_quiesce_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : munoc_axi_quiesce_ctrl                                       |
// | Description : Quiesces an AXI port: stops new addresses, waits for all    |
// |               in-flight bursts (or a timeout), then raises the isolation   |
// |               gate and acknowledges.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module munoc_axi_quiesce_ctrl
  import munoc_axi_quiesce_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  wire logic               clk,
  input  wire logic               rstnn,
  input  wire logic               isolate_req,
  munoc_axi_quiesce_ctrl_if.slave axi,
  output logic                    block_new,
  output logic                    block,
  output logic                    isolate_ack,
  output logic                    drain_timeout,
  output logic                    cnt_error
);

  localparam int BW_CNT = clog2p1(MAX_OUTSTANDING);
  localparam int BW_TMR = clog2p1(TIMEOUT_CYCLES);
  localparam int WD_W   = BW_CNT + 1;

  localparam logic [BW_TMR-1:0]      C_TMR_LAST = BW_TMR'(TIMEOUT_CYCLES - 1);
  localparam logic [BW_TMR-1:0]      C_TMR_ONE  = BW_TMR'(1);
  localparam logic signed [WD_W-1:0] C_WD_ONE   = WD_W'(1);

  logic aw_fire, w_last_fire, b_fire, ar_fire, r_last_fire, addr_stall;

  assign aw_fire     = axi.awvalid & axi.awready;
  assign w_last_fire = axi.wvalid  & axi.wready & axi.wlast;
  assign b_fire      = axi.bvalid  & axi.bready;
  assign ar_fire     = axi.arvalid & axi.arready;
  assign r_last_fire = axi.rvalid  & axi.rready & axi.rlast;
  // A stalled address beat must complete before masking its valid upstream
  assign addr_stall  = (axi.awvalid & ~axi.awready) | (axi.arvalid & ~axi.arready);

  logic [BW_CNT-1:0] wr_cnt_nxt, rd_cnt_nxt;
  logic              wr_err, rd_err;

  munoc_quiesce_counter #(.MAX_VAL(MAX_OUTSTANDING), .BW(BW_CNT)) u_wr_cnt (
    .clk       (clk),
    .rstnn     (rstnn),
    .inc       (aw_fire),
    .dec       (b_fire),
    .count_nxt (wr_cnt_nxt),
    .err       (wr_err)
  );

  munoc_quiesce_counter #(.MAX_VAL(MAX_OUTSTANDING), .BW(BW_CNT)) u_rd_cnt (
    .clk       (clk),
    .rstnn     (rstnn),
    .inc       (ar_fire),
    .dec       (r_last_fire),
    .count_nxt (rd_cnt_nxt),
    .err       (rd_err)
  );

  logic signed [WD_W-1:0] wd_bal_q, wd_bal_d;
  qstate_e                state_q, state_d;
  logic [BW_TMR-1:0]      timer_q, timer_d;
  logic                   drain_timeout_q, drain_timeout_d;
  logic                   block_new_q, block_new_d;
  logic                   block_q, block_d;
  logic                   isolate_ack_q, isolate_ack_d;
  logic                   drained_nxt;

  // Write-data balance: address accepted vs last data beat accepted
  always_comb begin
    wd_bal_d = wd_bal_q;
    if (aw_fire && !w_last_fire)      wd_bal_d = wd_bal_q + C_WD_ONE;
    else if (!aw_fire && w_last_fire) wd_bal_d = wd_bal_q - C_WD_ONE;
  end

  // Drained is judged on the counts including this cycle's fires
  assign drained_nxt = (wr_cnt_nxt == '0) && (rd_cnt_nxt == '0) && (wd_bal_d == '0);

  // Quiesce FSM next state, timer, timeout flag and registered output values
  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    drain_timeout_d = drain_timeout_q;
    case (state_q)
      ST_OPEN: begin
        if (isolate_req && !addr_stall) begin
          state_d         = ST_DRAIN;
          timer_d         = '0;
          drain_timeout_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        timer_d = timer_q + C_TMR_ONE;
        if (!isolate_req) begin
          state_d = ST_OPEN;
        end else if (drained_nxt) begin
          state_d = ST_ISOLATED;
        end else if (timer_q == C_TMR_LAST) begin
          state_d         = ST_ISOLATED;
          drain_timeout_d = 1'b1;
        end
      end
      ST_ISOLATED: begin
        if (!isolate_req) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
    block_new_d   = (state_d != ST_OPEN);
    block_d       = (state_d == ST_ISOLATED);
    isolate_ack_d = (state_d == ST_ISOLATED);
  end

  // State, timer, balance and output registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q         <= ST_OPEN;
      timer_q         <= '0;
      wd_bal_q        <= '0;
      drain_timeout_q <= 1'b0;
      block_new_q     <= 1'b0;
      block_q         <= 1'b0;
      isolate_ack_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      wd_bal_q        <= wd_bal_d;
      drain_timeout_q <= drain_timeout_d;
      block_new_q     <= block_new_d;
      block_q         <= block_d;
      isolate_ack_q   <= isolate_ack_d;
    end
  end

  assign block_new     = block_new_q;
  assign block         = block_q;
  assign isolate_ack   = isolate_ack_q;
  assign drain_timeout = drain_timeout_q;
  assign cnt_error     = wr_err | rd_err;

endmodule
`default_nettype wire

// File: tb/tb_munoc_axi_quiesce_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_munoc_axi_quiesce_ctrl                                    |
// | Description : Directed bench for the AXI quiesce controller. Expected     |
// |               outputs {block_new,block,isolate_ack,drain_timeout,          |
// |               cnt_error} are queued by the stimulus and compared by an     |
// |               independent monitor on the falling clock edge.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_munoc_axi_quiesce_ctrl;

  logic clk = 1'b0;
  logic rstnn;
  logic isolate_req;
  logic block_new, block, isolate_ack, drain_timeout, cnt_error;

  munoc_axi_quiesce_ctrl_if axi ();

  munoc_axi_quiesce_ctrl #(
    .MAX_OUTSTANDING (2),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk           (clk),
    .rstnn         (rstnn),
    .isolate_req   (isolate_req),
    .axi           (axi),
    .block_new     (block_new),
    .block         (block),
    .isolate_ack   (isolate_ack),
    .drain_timeout (drain_timeout),
    .cnt_error     (cnt_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: compare the queued expectation for this cycle
  always @(negedge clk) begin
    exp_t       t;
    logic [4:0] got;
    if (sb_q.size() > 0) begin
      t   = sb_q.pop_front();
      got = {block_new, block, isolate_ack, drain_timeout, cnt_error};
      checks++;
      if (got !== t.exp) begin
        failures++;
        $display("FAIL %s: {block_new,block,ack,timeout,err} got %b expected %b",
                 t.tag, got, t.exp);
      end
    end
  end

  task automatic expect_out(input string tag, input logic [4:0] e);
    exp_t t;
    t.tag = tag;
    t.exp = e;
    sb_q.push_back(t);
  endtask

  task automatic idle();
    axi.awvalid = 1'b0; axi.awready = 1'b0;
    axi.wvalid  = 1'b0; axi.wready  = 1'b0; axi.wlast = 1'b0;
    axi.bvalid  = 1'b0; axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.arready = 1'b0;
    axi.rvalid  = 1'b0; axi.rready  = 1'b0; axi.rlast = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic fire_aw();   axi.awvalid = 1'b1; axi.awready = 1'b1; endtask
  task automatic fire_wlast(); axi.wvalid = 1'b1; axi.wready = 1'b1; axi.wlast = 1'b1; endtask
  task automatic fire_b();    axi.bvalid = 1'b1; axi.bready = 1'b1; endtask
  task automatic fire_ar();   axi.arvalid = 1'b1; axi.arready = 1'b1; endtask
  task automatic fire_r(input logic last);
    axi.rvalid = 1'b1; axi.rready = 1'b1; axi.rlast = last;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstnn       = 1'b0;
    isolate_req = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 5'b00000);
    next();
    rstnn = 1'b1;

    // Idle port: block_new after one cycle, block/ack after two
    isolate_req = 1'b1; expect_out("idle_c0", 5'b00000); next();
    expect_out("idle_c1", 5'b10000); next();
    expect_out("idle_c2", 5'b11100); next();
    isolate_req = 1'b0; expect_out("idle_hold", 5'b11100); next();
    expect_out("idle_open", 5'b00000); next();

    // Two writes and one read outstanding must all complete first
    fire_aw(); next();
    fire_aw(); next();
    fire_ar(); next();
    isolate_req = 1'b1; expect_out("busy_req", 5'b00000); next();
    fire_wlast(); expect_out("busy_w1", 5'b10000); next();
    fire_wlast(); expect_out("busy_w2", 5'b10000); next();
    fire_b(); fire_r(1'b0); expect_out("busy_b1", 5'b10000); next();
    fire_b(); expect_out("busy_b2", 5'b10000); next();
    fire_r(1'b1); expect_out("busy_rlast", 5'b10000); next();
    expect_out("busy_iso", 5'b11100); next();
    isolate_req = 1'b0; expect_out("busy_hold", 5'b11100); next();
    expect_out("busy_open", 5'b00000); next();

    // Stalled AW delays DRAIN entry until it is accepted
    isolate_req = 1'b1; axi.awvalid = 1'b1; expect_out("stall_c0", 5'b00000); next();
    axi.awvalid = 1'b1; expect_out("stall_c1", 5'b00000); next();
    fire_aw(); expect_out("stall_fire", 5'b00000); next();
    expect_out("stall_drain", 5'b10000); next();
    fire_wlast(); fire_b(); expect_out("stall_done", 5'b10000); next();
    expect_out("stall_iso", 5'b11100); next();
    isolate_req = 1'b0; next();
    expect_out("stall_open", 5'b00000); next();

    // AW and B in the same cycle leave wr_cnt unchanged at 1
    fire_aw(); next();
    fire_aw(); fire_b(); next();
    isolate_req = 1'b1; expect_out("same_req", 5'b00000); next();
    fire_wlast(); expect_out("same_w1", 5'b10000); next();
    fire_wlast(); expect_out("same_w2", 5'b10000); next();
    fire_b(); expect_out("same_wr_held", 5'b10000); next();
    expect_out("same_iso", 5'b11100); next();
    isolate_req = 1'b0; next();
    expect_out("same_open", 5'b00000); next();

    // Withdrawal wins over drained in the same cycle
    fire_aw(); next();
    isolate_req = 1'b1; expect_out("wd_req", 5'b00000); next();
    isolate_req = 1'b0; fire_wlast(); fire_b(); expect_out("wd_drain", 5'b10000); next();
    expect_out("wd_open", 5'b00000); next();
    expect_out("wd_stay", 5'b00000); next();

    // Missing B: forced isolation 16 cycles after DRAIN entry
    fire_aw(); fire_wlast(); next();
    isolate_req = 1'b1; expect_out("to_req", 5'b00000); next();
    for (int k = 0; k < 16; k++) begin
      expect_out($sformatf("to_drain%0d", k), 5'b10000);
      next();
    end
    expect_out("to_iso", 5'b11110); next();
    isolate_req = 1'b0; expect_out("to_hold", 5'b11110); next();
    fire_b(); expect_out("to_sticky", 5'b00010); next();

    // Re-entering DRAIN clears the timeout flag; async reset in ISOLATED
    isolate_req = 1'b1; expect_out("re_req", 5'b00010); next();
    expect_out("re_drain", 5'b10000); next();
    expect_out("re_iso", 5'b11100); next();
    rstnn = 1'b0; isolate_req = 1'b0; expect_out("async_rst", 5'b00000); next();
    rstnn = 1'b1; expect_out("post_rst", 5'b00000); next();

    // Read counter overflow at MAX_OUTSTANDING=2 saturates and flags
    fire_ar(); expect_out("ovf_ar1", 5'b00000); next();
    fire_ar(); expect_out("ovf_ar2", 5'b00000); next();
    fire_ar(); expect_out("ovf_ar3", 5'b00000); next();
    fire_r(1'b1); expect_out("ovf_err", 5'b00001); next();
    fire_r(1'b1); expect_out("ovf_r2", 5'b00001); next();
    isolate_req = 1'b1; expect_out("ovf_req", 5'b00001); next();
    expect_out("ovf_drain", 5'b10001); next();
    expect_out("ovf_iso", 5'b11101); next();
    isolate_req = 1'b0; next();
    expect_out("ovf_open", 5'b00001); next();

    // Write counter underflow at zero holds and flags
    rstnn = 1'b0; expect_out("udf_rst", 5'b00000); next();
    rstnn = 1'b1; fire_b(); expect_out("udf_b", 5'b00000); next();
    expect_out("udf_err", 5'b00001); next();
    isolate_req = 1'b1; expect_out("udf_req", 5'b00001); next();
    expect_out("udf_drain", 5'b10001); next();
    expect_out("udf_iso", 5'b11101); next();
    isolate_req = 1'b0; next();

    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
